// File: rtl/datapath_sequencer.sv
// Multicycle control sequencer for the FullDMRFALU datapath.
// Optional addi support is compiled in with SEQ_ADDI_EN.
module datapath_sequencer #(
    parameter logic [5:0] OP_RTYPE = 6'b000000,
    parameter logic [5:0] OP_LW    = 6'b100011,
    parameter logic [5:0] OP_SW    = 6'b101011,
    parameter logic [5:0] OP_BEQ   = 6'b000100
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        instr_valid,
    input  logic [31:0] instr,
    output logic        instr_ready,
    input  logic        Zero,
    output logic        RegWrite,
    output logic        MemWrite,
    output logic        MemRead,
    output logic        MemToReg,
    output logic        ALUSrc,
    output logic [1:0]  ALUOp,
    output logic [5:0]  FuncCode,
    output logic [4:0]  Read1,
    output logic [4:0]  Read2,
    output logic [4:0]  WriteReg,
    output logic [31:0] Imm,
    output logic        done,
    output logic        branch_taken,
    output logic        illegal
);

    typedef enum logic [2:0] {
        IDLE,
        DECODE,
        EXEC,
        MEM,
        WB
    } state_t;

    state_t      state;
    state_t      state_nx;
    logic [31:0] ir;
    logic        loaded;
    logic [5:0]  op;
    logic        is_r;
    logic        is_lw;
    logic        is_sw;
    logic        is_beq;
    logic        is_addi;
    logic        supported;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            ir     <= '0;
            loaded <= 1'b0;
        end else begin
            state <= state_nx;
            if (state == IDLE && instr_valid) begin
                ir     <= instr;
                loaded <= 1'b1;
            end
        end
    end

    // ir resets to an R-type encoding, so gate on loaded
    assign op     = ir[31:26];
    assign is_r   = loaded && (op == OP_RTYPE);
    assign is_lw  = (op == OP_LW);
    assign is_sw  = (op == OP_SW);
    assign is_beq = (op == OP_BEQ);
`ifdef SEQ_ADDI_EN
    assign is_addi = (op == 6'b001000);
`else
    assign is_addi = 1'b0;
`endif
    assign supported = is_r | is_lw | is_sw | is_beq | is_addi;

    assign instr_ready = (state == IDLE) && !rst;
    assign Read1       = ir[25:21];
    assign Read2       = ir[20:16];
    assign FuncCode    = ir[5:0];
    assign Imm         = {{16{ir[15]}}, ir[15:0]};
    assign MemToReg    = is_lw;
    assign ALUSrc      = is_lw | is_sw | is_addi;

    always_comb begin
        ALUOp = 2'b00;
        if (is_r)
            ALUOp = 2'b10;
        else if (is_beq)
            ALUOp = 2'b01;
    end

    always_comb begin
        WriteReg = 5'd0;
        if (is_r)
            WriteReg = ir[15:11];
        else if (is_lw || is_addi)
            WriteReg = ir[20:16];
    end

    always_comb begin
        state_nx     = state;
        RegWrite     = 1'b0;
        MemWrite     = 1'b0;
        MemRead      = 1'b0;
        done         = 1'b0;
        branch_taken = 1'b0;
        illegal      = 1'b0;
        unique case (state)
            IDLE: begin
                if (instr_valid)
                    state_nx = DECODE;
            end
            DECODE: begin
                if (supported) begin
                    state_nx = EXEC;
                end else begin
                    illegal  = 1'b1;
                    done     = 1'b1;
                    state_nx = IDLE;
                end
            end
            EXEC: begin
                if (is_beq) begin
                    done         = 1'b1;
                    branch_taken = Zero;
                    state_nx     = IDLE;
                end else if (is_lw || is_sw) begin
                    state_nx = MEM;
                end else begin
                    state_nx = WB;
                end
            end
            MEM: begin
                if (is_lw) begin
                    MemRead  = 1'b1;
                    state_nx = WB;
                end else begin
                    MemWrite = 1'b1;
                    done     = 1'b1;
                    state_nx = IDLE;
                end
            end
            WB: begin
                RegWrite = (WriteReg != 5'd0);
                done     = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

endmodule

// File: tb/tb_datapath_sequencer.sv
// Directed scoreboard bench for datapath_sequencer.
module tb_datapath_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        instr_valid;
    logic [31:0] instr;
    logic        instr_ready;
    logic        Zero;
    logic        RegWrite, MemWrite, MemRead, MemToReg, ALUSrc;
    logic [1:0]  ALUOp;
    logic [5:0]  FuncCode;
    logic [4:0]  Read1, Read2, WriteReg;
    logic [31:0] Imm;
    logic        done, branch_taken, illegal;

    int vectors = 0;
    int fails   = 0;

    typedef struct {
        int lat;
        int rw;
        int mw;
        int mr;
        int bt;
        int ill;
        int wreg;
        int r1;
        int r2;
        int imm;
        int aluop;
        int alusrc;
        int m2r;
        int fc;
    } exp_t;

    exp_t q[$];

    datapath_sequencer dut (
        .clk(clk), .rst(rst),
        .instr_valid(instr_valid), .instr(instr),
        .instr_ready(instr_ready), .Zero(Zero),
        .RegWrite(RegWrite), .MemWrite(MemWrite),
        .MemRead(MemRead), .MemToReg(MemToReg),
        .ALUSrc(ALUSrc), .ALUOp(ALUOp),
        .FuncCode(FuncCode), .Read1(Read1),
        .Read2(Read2), .WriteReg(WriteReg),
        .Imm(Imm), .done(done),
        .branch_taken(branch_taken), .illegal(illegal)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        vectors++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic exp_t model(input logic [31:0] i, input logic z);
        exp_t e;
        logic [5:0] op;
        logic r, lw, sw, beq, addi;
        op   = i[31:26];
        r    = (op == 6'b000000);
        lw   = (op == 6'b100011);
        sw   = (op == 6'b101011);
        beq  = (op == 6'b000100);
`ifdef SEQ_ADDI_EN
        addi = (op == 6'b001000);
`else
        addi = 1'b0;
`endif
        e.lat = r ? 3 : lw ? 4 : sw ? 3 : beq ? 2 : addi ? 3 : 1;
        e.wreg = r ? int'(i[15:11]) : (lw || addi) ? int'(i[20:16]) : 0;
        e.rw = ((r || lw || addi) && e.wreg != 0) ? e.lat : 0;
        e.mw = sw ? 3 : 0;
        e.mr = lw ? 3 : 0;
        e.bt = (beq && z) ? 1 : 0;
        e.ill = (r || lw || sw || beq || addi) ? 0 : 1;
        e.r1 = int'(i[25:21]);
        e.r2 = int'(i[20:16]);
        e.imm = int'({{16{i[15]}}, i[15:0]});
        e.aluop = r ? 2 : beq ? 1 : 0;
        e.alusrc = (lw || sw || addi) ? 1 : 0;
        e.m2r = lw ? 1 : 0;
        e.fc = int'(i[5:0]);
        return e;
    endfunction

    task automatic run(input logic [31:0] i, input logic z);
        int rw_c, mw_c, mr_c, bt_v, ill_v, rdy_n, pulses, cyc;
        exp_t e;
        @(negedge clk);
        chk("ready_idle", int'(instr_ready), 1);
        instr_valid = 1'b1;
        instr = i;
        Zero = z;
        q.push_back(model(i, z));
        rw_c = 0; mw_c = 0; mr_c = 0;
        bt_v = 0; ill_v = 0; rdy_n = 0; pulses = 0;
        cyc = 0;
        while (cyc < 10) begin
            @(negedge clk);
            cyc++;
            instr_valid = 1'b0;
            instr = $urandom;
            if (RegWrite) begin rw_c = cyc; pulses++; end
            if (MemWrite) begin mw_c = cyc; pulses++; end
            if (MemRead) begin mr_c = cyc; pulses++; end
            if (branch_taken) bt_v = 1;
            if (illegal) ill_v = 1;
            if (instr_ready) rdy_n++;
            if (done) break;
        end
        e = q.pop_front();
        chk("latency", cyc, e.lat);
        chk("regwrite_cyc", rw_c, e.rw);
        chk("memwrite_cyc", mw_c, e.mw);
        chk("memread_cyc", mr_c, e.mr);
        chk("strobe_pulses", pulses,
            (e.rw != 0 ? 1 : 0) + (e.mw != 0 ? 1 : 0) + (e.mr != 0 ? 1 : 0));
        chk("branch_taken", bt_v, e.bt);
        chk("illegal", ill_v, e.ill);
        chk("ready_busy", rdy_n, 0);
        chk("writereg", int'(WriteReg), e.wreg);
        chk("read1", int'(Read1), e.r1);
        chk("read2", int'(Read2), e.r2);
        chk("imm", int'(Imm), e.imm);
        chk("aluop", int'(ALUOp), e.aluop);
        chk("alusrc", int'(ALUSrc), e.alusrc);
        chk("memtoreg", int'(MemToReg), e.m2r);
        chk("funccode", int'(FuncCode), e.fc);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_ready"}, int'(instr_ready), 0);
        chk({tag, "_strobes"},
            int'({RegWrite, MemWrite, MemRead, done, branch_taken, illegal}), 0);
        chk({tag, "_selects"}, int'({MemToReg, ALUSrc, ALUOp}), 0);
        chk({tag, "_regs"}, int'({Read1, Read2, WriteReg}), 0);
        chk({tag, "_imm"}, int'(Imm), 0);
        chk({tag, "_fc"}, int'(FuncCode), 0);
    endtask

    initial begin
        rst = 1'b1;
        instr_valid = 1'b0;
        instr = '0;
        Zero = 1'b0;
        repeat (2) @(negedge clk);
        chk_all_zero("reset");
        rst = 1'b0;
        #1;
        chk("ready_after_reset", int'(instr_ready), 1);
        chk("aluop_after_reset", int'(ALUOp), 0);

        run(32'h00221820, 1'b0);
        run(32'h8C850008, 1'b0);
        run(32'hAC85FFFC, 1'b0);
        run(32'h10220003, 1'b1);
        run(32'h10220003, 1'b0);
        run(32'h3C010001, 1'b0);
        run(32'h20010005, 1'b0);
        run(32'h00220020, 1'b0);
        run(32'h8C800004, 1'b1);
        run(32'h0085302A, 1'b0);

        // reset in the MEM cycle of a store
        @(negedge clk);
        instr_valid = 1'b1;
        instr = 32'hAC85FFFC;
        repeat (3) begin
            @(negedge clk);
            instr_valid = 1'b0;
        end
        chk("sw_mem_write", int'(MemWrite), 1);
        rst = 1'b1;
        #1;
        chk("rst_memwrite", int'(MemWrite), 0);
        chk_all_zero("midreset");
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("ready_after_midreset", int'(instr_ready), 1);
        run(32'h00221820, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule
